// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// error flags, synchronous flush and a selectable standard/FWFT read port.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: WIDTH must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overflow_q, underflow_q;
  logic             full_w, empty_w, wr_acc, rd_acc;

  // Acceptance is judged on the registered count, so a full FIFO never
  // passes a same-cycle write through to a simultaneous read.
  always_comb begin
    full_w  = (count_q == DEPTH_C);
    empty_w = (count_q == '0);
    wr_acc  = wr_en & ~full_w;
    rd_acc  = rd_en & ~empty_w;
    count_d = count_q;
    if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
    if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      rd_valid_q <= rd_acc;
      count_q    <= count_d;
      if (wr_en && full_w)  overflow_q  <= 1'b1;
      if (rd_en && empty_w) underflow_q <= 1'b1;
    end
  end

  // FWFT presents the head word directly; standard mode uses the read register.
  always_comb begin
    rd_data      = (FWFT != 0) ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid     = (FWFT != 0) ? ~empty_w : rd_valid_q;
    full         = full_w;
    empty        = empty_w;
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: one standard-mode and one FWFT instance share stimulus;
// a queue model predicts occupancy, flags and read data for both.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] wr_data;

  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b, full_a, full_b, afull_a, afull_b;
  logic       empty_a, empty_b, aempty_a, aempty_b, ovf_a, ovf_b, unf_a, unf_b;
  logic [2:0] count_a, count_b;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  logic       m_ovf, m_unf, m_rdv;
  logic [7:0] m_rdd;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .full(full_a), .almost_full(afull_a),
    .empty(empty_a), .almost_empty(aempty_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a));

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .full(full_b), .almost_full(afull_b),
    .empty(empty_b), .almost_empty(aempty_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    int c;
    c = sb_q.size();
    check_val("std_count",  32'(count_a),  32'(c));
    check_val("std_full",   32'(full_a),   32'(c == 4));
    check_val("std_afull",  32'(afull_a),  32'(c >= 3));
    check_val("std_empty",  32'(empty_a),  32'(c == 0));
    check_val("std_aempty", 32'(aempty_a), 32'(c <= 1));
    check_val("std_ovf",    32'(ovf_a),    32'(m_ovf));
    check_val("std_unf",    32'(unf_a),    32'(m_unf));
    check_val("std_rdv",    32'(rd_valid_a), 32'(m_rdv));
    check_val("std_rdata",  32'(rd_data_a),  32'(m_rdd));
    check_val("fwft_count", 32'(count_b),  32'(c));
    check_val("fwft_full",  32'(full_b),   32'(c == 4));
    check_val("fwft_empty", 32'(empty_b),  32'(c == 0));
    check_val("fwft_ovf",   32'(ovf_b),    32'(m_ovf));
    check_val("fwft_unf",   32'(unf_b),    32'(m_unf));
    check_val("fwft_rdv",   32'(rd_valid_b), 32'(c != 0));
    if (c != 0) check_val("fwft_rdata", 32'(rd_data_b), 32'(sb_q[0]));
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic fl, input logic w, input logic [7:0] d,
                      input logic rd);
    logic full_m, empty_m;
    rst = r; flush = fl; wr_en = w; wr_data = d; rd_en = rd;
    full_m  = (sb_q.size() == 4);
    empty_m = (sb_q.size() == 0);
    @(posedge clk);
    if (r) begin
      sb_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00;
    end else if (fl) begin
      sb_q.delete();
      m_rdv = 1'b0;
    end else begin
      if (w && full_m)   m_ovf = 1'b1;
      if (rd && empty_m) m_unf = 1'b1;
      if (rd && !empty_m) begin
        m_rdd = sb_q.pop_front();
        m_rdv = 1'b1;
      end else begin
        m_rdv = 1'b0;
      end
      if (w && !full_m) sb_q.push_back(d);
    end
    #1;
    compare_all();
  endtask

  initial begin
    m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00;
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);

    // Fill to full, then an overflowing write.
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 0, 1, 8'h33, 0);
    step(0, 0, 1, 8'h44, 0);
    step(0, 0, 1, 8'h55, 0);
    // Full with both requested: read wins, write rejected.
    step(0, 0, 1, 8'h66, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);
    // Underflow while empty; rd_data must hold.
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    step(1, 0, 0, 8'h00, 0);
    // Empty with both requested: write wins, underflow set.
    step(0, 0, 1, 8'h70, 1);
    step(0, 0, 1, 8'h71, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h80 + 8'(i), 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    // Flush with a coincident write, then reset mid-burst.
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h90, 0);
    step(0, 0, 1, 8'h91, 0);
    step(0, 0, 1, 8'h92, 0);
    step(0, 1, 1, 8'h93, 1);
    step(0, 0, 1, 8'hA5, 0);
    step(0, 0, 1, 8'hA6, 1);
    step(0, 0, 1, 8'hA7, 1);
    step(1, 0, 1, 8'hA8, 1);
    step(0, 0, 0, 8'h00, 0);

    for (int i = 0; i < 300; i++)
      step(0, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
